// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: radix-2 shift-add multiply, restoring divide.
// Each operation takes WIDTH+2 cycles from accept to done; results are held in HI/LO.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

   state_t             r_state, w_next;
   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_a, r_b;
   logic [WIDTH-1:0]   r_m;      // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   r_acc;    // product upper half or partial remainder
   logic [WIDTH-1:0]   r_sh;     // multiplier / dividend, shifting into product low half / quotient
   logic [CW-1:0]      r_cnt;
   logic               r_neg_q, r_neg_r;
   logic               r_busy, r_done, r_dbz;
   logic [WIDTH-1:0]   r_hi, r_lo;

   logic               w_is_div, w_signed, w_dbz, w_dge;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_dsub, w_quo, w_rem;
   logic [WIDTH:0]     w_msum, w_dshift;
   logic [2*WIDTH-1:0] w_prod, w_prod_s;

   assign w_is_div = r_op[1];
   assign w_signed = r_op[0];
   assign w_dbz    = w_is_div && (r_b == '0);
   assign w_a_mag  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
   assign w_b_mag  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

   assign w_msum   = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_m} : '0);

   // Partial remainder is WIDTH+1 bits wide so the compare is exact for any divisor.
   assign w_dshift = {r_acc, r_sh[WIDTH-1]};
   assign w_dge    = (w_dshift >= {1'b0, r_m});
   assign w_dsub   = w_dshift[WIDTH-1:0] - r_m;

   assign w_prod   = {r_acc, r_sh};
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;
   assign w_quo    = r_neg_q ? -r_sh : r_sh;
   assign w_rem    = r_neg_r ? -r_acc : r_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_PREP;
         S_PREP:  w_next = S_RUN;
         S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_m     <= '0;
         r_acc   <= '0;
         r_sh    <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op   <= op;
                  r_a    <= a;
                  r_b    <= b;
                  r_busy <= 1'b1;
               end
            end
            S_PREP: begin
               r_m     <= w_is_div ? w_b_mag : w_a_mag;
               r_sh    <= w_is_div ? w_a_mag : w_b_mag;
               r_acc   <= '0;
               r_cnt   <= '0;
               r_neg_q <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
               r_neg_r <= w_signed && r_a[WIDTH-1];
            end
            S_RUN: begin
               r_cnt <= r_cnt + CW'(1);
               if (w_is_div) begin
                  r_acc <= w_dge ? w_dsub : w_dshift[WIDTH-1:0];
                  r_sh  <= {r_sh[WIDTH-2:0], w_dge};
               end else begin
                  r_acc <= w_msum[WIDTH:1];
                  r_sh  <= {w_msum[0], r_sh[WIDTH-1:1]};
               end
            end
            S_FIX: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_dbz  <= w_dbz;
               if (w_dbz) begin
                  r_hi <= r_a;
                  r_lo <= '1;
               end else if (w_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_s[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, random ops against a 64-bit arithmetic
// model, plus hand sequences for ignored start, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
   localparam int W   = 32;
   localparam int LAT = W + 2;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [1:0]   op;
   logic [W-1:0] a, b, hi, lo;
   logic         busy, done, dbz;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, hi, lo;
      logic         dbz;
   } vec_t;

   vec_t vecs[12];

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic. SV signed / and % truncate toward zero.
   task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
      longint      sx, sy, sq, sr;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ed = 1'b0;
      p  = '0;
      if (o == 2'b00) begin
         p = {32'b0, x} * {32'b0, y};
         eh = p[63:32]; el = p[31:0];
      end else if (o == 2'b01) begin
         p = sx * sy;
         eh = p[63:32]; el = p[31:0];
      end else if (y == '0) begin
         eh = x; el = '1; ed = 1'b1;
      end else if (o == 2'b10) begin
         el = x / y; eh = x % y;
      end else begin
         sq = sx / sy; sr = sx % sy;
         el = sq[31:0]; eh = sr[31:0];
      end
   endtask

   task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts edges after the accept edge until done; optionally pulses start on cycle inj.
   task automatic wait_done(input int inj, output int lat, output bit bok);
      lat = 0;
      bok = (busy === 1'b1);
      while (lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         if (inj >= 0 && lat == inj + 1) start = 1'b0;
         if (done === 1'b1) break;
         if (busy !== 1'b1) bok = 1'b0;
         if (lat == inj) begin
            start = 1'b1; op = ~op; a = $urandom; b = $urandom;
         end
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic ed, input int inj);
      int lat;
      bit bok;
      start_op(o, x, y);
      wait_done(inj, lat, bok);
      $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b lat=%0d", name, o, x, y, hi, lo, dbz, lat);
      chk({name, ".lat"},  64'(lat), 64'(LAT));
      chk({name, ".busy"}, {63'b0, bok}, 64'd1);
      chk({name, ".bfall"}, {63'b0, busy}, 64'd0);
      chk({name, ".hi"},   {32'b0, hi}, {32'b0, eh});
      chk({name, ".lo"},   {32'b0, lo}, {32'b0, el});
      chk({name, ".dbz"},  {63'b0, dbz}, {63'b0, ed});
      @(posedge clk);
      #1;
      chk({name, ".dfall"}, {63'b0, done}, 64'd0);
      chk({name, ".hold"}, {hi, lo}, {eh, el});
   endtask

   initial begin
      logic [W-1:0] eh, el, x, y;
      logic         ed;
      logic [1:0]   o;
      int           lat, nd;
      bit           bok;

      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;

      vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[4]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[5]  = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
      vecs[6]  = '{2'b10, 32'd10,       32'd5,        32'd0,        32'd2,        1'b0};
      vecs[7]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[8]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
      vecs[9]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
      vecs[10] = '{2'b11, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'd0,        32'd4,        1'b0};
      vecs[11] = '{2'b00, 32'h00000000, 32'h12345678, 32'd0,        32'd0,        1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", {63'b0, busy}, 64'd0);
      chk("rst.done", {63'b0, done}, 64'd0);
      chk("rst.hilo", {hi, lo}, 64'd0);
      chk("rst.dbz",  {63'b0, dbz}, 64'd0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].dbz, -1);

      // start pulsed mid-operation with a different op must be ignored
      run_op("ignore", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 10);

      // start held high: refused at the done edge, accepted on the next one
      start_op(2'b00, 32'd9, 32'd9);
      op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
      wait_done(-1, lat, bok);
      $display("b2b1 op=0 a=9 b=9 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
      chk("b2b1.lat", 64'(lat), 64'(LAT));
      chk("b2b1.lo",  {32'b0, lo}, 64'd81);
      chk("b2b1.busy", {63'b0, busy}, 64'd0);
      @(posedge clk);
      #1 start = 1'b0;
      chk("b2b2.acc", {63'b0, busy}, 64'd1);
      wait_done(-1, lat, bok);
      $display("b2b2 op=0 a=2 b=3 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
      chk("b2b2.lat", 64'(lat), 64'(LAT));
      chk("b2b2.lo",  {hi, lo}, 64'd6);

      for (int i = 0; i < 50; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = '0;
            1: x = 32'h80000000;
            2: y = 32'hFFFFFFFF;
            3: y = 32'($urandom_range(1, 15));
            default: ;
         endcase
         model(o, x, y, eh, el, ed);
         run_op($sformatf("rnd%0d", i), o, x, y, eh, el, ed, -1);
      end

      // make hi/lo nonzero, then reset in the middle of a MULTU
      run_op("pre", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, -1);
      start_op(2'b00, 32'h0000FFFF, 32'h0000FFFF);
      repeat (15) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      $display("reset mid-op -> busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
      chk("arst.busy", {63'b0, busy}, 64'd0);
      chk("arst.hilo", {hi, lo}, 64'd0);
      chk("arst.done", {63'b0, done}, 64'd0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      nd = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) nd++;
      end
      chk("arst.nodone", 64'(nd), 64'd0);
      run_op("post", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with a HI/LO result pair and a start/busy/done handshake. It sits beside the single-cycle ALU in the MIPS datapath and executes MULT, MULTU, DIV and DIVU over WIDTH+2 cycles. Operand width is parametrised, and results are held stable between operations. The controller stalls the pipeline on `busy` and captures `hi`/`lo` when `done` pulses.

## Interface
- WIDTH, default 32: operand width and the width of each of `hi` and `lo`; must be at least 4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only when `busy`=0.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- a  in  WIDTH  multiplicand or dividend; sampled with `start`.
- b  in  WIDTH  multiplier or divisor; sampled with `start`.
- busy  out  1  operation in progress.
- done  out  1  single-cycle pulse when `hi`/`lo` become valid.
- hi  out  WIDTH  product upper half, or remainder.
- lo  out  WIDTH  product lower half, or quotient.
- div_by_zero  out  1  divisor was 0 in the last operation; valid from `done` until the next accepted `start`.

## Operation
- States:
  - IDLE: `start`=1 latches `op`, `a` and `b`, then goes to PREP.
  - PREP: takes the magnitudes of signed operands, records result signs, clears the iteration counter, then goes to RUN.
  - RUN: performs exactly WIDTH iterations, then goes to FIX.
  - FIX: applies signs, loads `hi`/`lo`, raises `done`, then goes to IDLE.
- Multiply: radix-2 shift-add on the unsigned magnitudes, producing a 2·WIDTH product. For MULT, the product is negated if the operand signs differ. `hi` gets the upper WIDTH bits and `lo` the lower WIDTH bits.
- Divide: restoring shift-subtract on the magnitudes. `lo` gets the quotient, which truncates toward zero. `hi` gets the remainder, which takes the sign of the dividend. For DIV, the quotient is negated if the signs differ.
- Divide by zero (b=0, DIV or DIVU):
  - Full latency still applies.
  - `lo` = all ones, `hi` = `a` unmodified, `div_by_zero`=1.
- Signed overflow (DIV, a = most-negative, b = −1): `lo` = most-negative, `hi` = 0. This falls out of the magnitude algorithm with no special case.
- Internal arithmetic uses WIDTH+1 bits for the partial remainder so the most-negative magnitude (2^(WIDTH−1)) is exact.
- `start` while `busy`=1 is ignored: no latch, no queueing, in-flight results unaffected.
- `hi`, `lo` and `div_by_zero` hold their values through IDLE and are overwritten only in FIX.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0; counter 0.
- Reset in any state aborts the operation immediately, and outputs take their reset values asynchronously. No `done` is issued for the aborted operation.
- Cycle numbering: start accepted at edge E0.
  - `busy`=1 from E0 until edge E(WIDTH+2).
  - At E(WIDTH+2), `busy` falls, `done` rises and `hi`/`lo`/`div_by_zero` update, all on the same edge.
  - `done` falls at E(WIDTH+3).
- Latency is WIDTH+2 cycles for every op and every operand, including b=0.
- Back-to-back: `start` sampled at E(WIDTH+2) is not accepted, because `busy` is still 1 during that cycle. The earliest next accept is E(WIDTH+3), which gives a throughput of one op per WIDTH+3 cycles.
- Outputs are registered. There is no combinational path from `a`/`b`/`op` to any output.

## Test plan
- MULTU, a=b=0xFFFFFFFF -> `done` exactly 34 cycles after the start edge, `hi`=0xFFFFFFFE, `lo`=0x00000001, `busy` high for cycles 1–34.
- MULT, a=−3 (0xFFFFFFFD), b=7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Then MULT, a=0x80000000, b=0x80000000 -> `hi`=0x40000000, `lo`=0.
- DIV, a=−7, b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then DIVU, a=100, b=7 -> `lo`=14, `hi`=2.
- DIVU, a=0x1234, b=0 -> `lo`=0xFFFFFFFF, `hi`=0x00001234, `div_by_zero`=1. The next DIVU, 10/5, -> `div_by_zero`=0, `lo`=2, `hi`=0.
- DIV, a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. Pulse `start` with a different op on cycle 10 -> ignored, result unchanged.
- Assert `rst` at cycle 15 of a MULTU -> `busy`, `hi` and `lo` go to 0 with no `done`. Start a new MULTU 6×7 after `rst` deasserts -> `lo`=42, `hi`=0, with standard latency.
